// File: rtl/id_operand_stage_if.sv
// ID -> EX operand stage bus: decoded instruction, regfile data, forwarding
// sources, pipeline control in; stall request, ID/EX register, counter out.
interface id_operand_stage_if #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NUM_FWD = 2,
  parameter int OPW     = 8,
  parameter int SELW    = 3,
  parameter int CNTW    = 16
);
  logic                    id_valid_i;
  logic [OPW-1:0]          id_aluop_i;
  logic [SELW-1:0]         id_alusel_i;
  logic [AW-1:0]           id_wd_i;
  logic                    id_wreg_i;
  logic [DW-1:0]           id_imm_i;
  logic                    id_rd1_i;
  logic                    id_rd2_i;
  logic [AW-1:0]           id_ra1_i;
  logic [AW-1:0]           id_ra2_i;
  logic [DW-1:0]           rf_data1_i;
  logic [DW-1:0]           rf_data2_i;
  logic [NUM_FWD-1:0]      fwd_wreg_i;
  logic [NUM_FWD*AW-1:0]   fwd_wd_i;
  logic [NUM_FWD*DW-1:0]   fwd_wdata_i;
  logic [NUM_FWD-1:0]      fwd_load_i;
  logic                    ex_ready_i;
  logic                    flush_i;
  logic                    clr_cnt_i;
  logic                    stall_req_o;
  logic                    interlock_o;
  logic                    ex_valid_o;
  logic [OPW-1:0]          ex_aluop_o;
  logic [SELW-1:0]         ex_alusel_o;
  logic [DW-1:0]           ex_reg1_o;
  logic [DW-1:0]           ex_reg2_o;
  logic [AW-1:0]           ex_wd_o;
  logic                    ex_wreg_o;
  logic [CNTW-1:0]         stall_cnt_o;

  modport slave (
    input  id_valid_i, id_aluop_i, id_alusel_i, id_wd_i, id_wreg_i, id_imm_i,
           id_rd1_i, id_rd2_i, id_ra1_i, id_ra2_i, rf_data1_i, rf_data2_i,
           fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_load_i,
           ex_ready_i, flush_i, clr_cnt_i,
    output stall_req_o, interlock_o, ex_valid_o, ex_aluop_o, ex_alusel_o,
           ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, stall_cnt_o
  );

  modport master (
    output id_valid_i, id_aluop_i, id_alusel_i, id_wd_i, id_wreg_i, id_imm_i,
           id_rd1_i, id_rd2_i, id_ra1_i, id_ra2_i, rf_data1_i, rf_data2_i,
           fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_load_i,
           ex_ready_i, flush_i, clr_cnt_i,
    input  stall_req_o, interlock_o, ex_valid_o, ex_aluop_o, ex_alusel_o,
           ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, stall_cnt_o
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode operand stage: per-source operand resolution (imm / r0 / forward /
// regfile), load-use interlock, ID/EX register with hold/flush/bubble and a
// saturating interlock-cycle counter.

// One source operand: immediate, zero register, youngest matching forward
// source, or regfile. A matching source whose load is still in flight
// raises hazard_o instead of supplying data.
module id_operand_resolve #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                  rd_i,
  input  logic [AW-1:0]         ra_i,
  input  logic [DW-1:0]         imm_i,
  input  logic [DW-1:0]         rf_data_i,
  input  logic [NUM_FWD-1:0]    fwd_wreg_i,
  input  logic [NUM_FWD*AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DW-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]    fwd_load_i,
  output logic [DW-1:0]         opnd_o,
  output logic                  hazard_o
);
  logic hit;

  // Priority scan: lowest index (youngest) match wins; r0 never matches.
  always_comb begin
    opnd_o   = rf_data_i;
    hazard_o = 1'b0;
    hit      = 1'b0;
    if (!rd_i) begin
      opnd_o = imm_i;
    end else if (ra_i == '0) begin
      opnd_o = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && fwd_wreg_i[i] && (fwd_wd_i[i*AW +: AW] == ra_i)) begin
          hit = 1'b1;
          if (fwd_load_i[i]) hazard_o = 1'b1;
          else               opnd_o   = fwd_wdata_i[i*DW +: DW];
        end
      end
    end
  end
endmodule

module id_operand_stage #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NUM_FWD = 2,
  parameter int OPW     = 8,
  parameter int SELW    = 3,
  parameter int CNTW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  id_operand_stage_if.slave bus
);
  localparam int NSRC = 2;

  typedef enum logic {RUN = 1'b0, INTERLOCK = 1'b1} state_t;

  typedef struct packed {
    logic            vld;
    logic [OPW-1:0]  aluop;
    logic [SELW-1:0] alusel;
    logic [DW-1:0]   reg1;
    logic [DW-1:0]   reg2;
    logic [AW-1:0]   wd;
    logic            wreg;
  } ex_t;

  logic [NSRC-1:0]         src_rd;
  logic [NSRC-1:0][AW-1:0] src_ra;
  logic [NSRC-1:0][DW-1:0] src_rf;
  logic [NSRC-1:0][DW-1:0] src_opnd;
  logic [NSRC-1:0]         src_haz;
  logic                    hazard;
  ex_t                     ex_d, ex_q;
  state_t                  state_q;
  logic [CNTW-1:0]         cnt_d, cnt_q;

  assign src_rd = {bus.id_rd2_i, bus.id_rd1_i};
  assign src_ra = {bus.id_ra2_i, bus.id_ra1_i};
  assign src_rf = {bus.rf_data2_i, bus.rf_data1_i};

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    id_operand_resolve #(.DW(DW), .AW(AW), .NUM_FWD(NUM_FWD)) u_res (
      .rd_i        (src_rd[k]),
      .ra_i        (src_ra[k]),
      .imm_i       (bus.id_imm_i),
      .rf_data_i   (src_rf[k]),
      .fwd_wreg_i  (bus.fwd_wreg_i),
      .fwd_wd_i    (bus.fwd_wd_i),
      .fwd_wdata_i (bus.fwd_wdata_i),
      .fwd_load_i  (bus.fwd_load_i),
      .opnd_o      (src_opnd[k]),
      .hazard_o    (src_haz[k])
    );
  end

  assign hazard          = bus.id_valid_i & (|src_haz);
  // Flush kills the ID instruction, so there is nothing left to hold.
  assign bus.stall_req_o = !bus.flush_i & bus.id_valid_i &
                           (hazard | !bus.ex_ready_i);

  // ID/EX next state: flush > hold > load > bubble. Hold beats a hazard
  // bubble so a stalled EX keeps its instruction.
  always_comb begin
    ex_d = '0;
    if (bus.flush_i) begin
      ex_d = '0;
    end else if (!bus.ex_ready_i) begin
      ex_d = ex_q;
    end else if (bus.id_valid_i && !hazard) begin
      ex_d.vld    = 1'b1;
      ex_d.aluop  = bus.id_aluop_i;
      ex_d.alusel = bus.id_alusel_i;
      ex_d.reg1   = src_opnd[0];
      ex_d.reg2   = src_opnd[1];
      ex_d.wd     = bus.id_wd_i;
      ex_d.wreg   = bus.id_wreg_i;
    end
  end

  // Interlock counter: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_cnt_i)                                cnt_d = '0;
    else if (hazard && !bus.flush_i && !(&cnt_q))     cnt_d = cnt_q + 1'b1;
  end

  // ID/EX register and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  // Interlock FSM: stays in INTERLOCK exactly while an unflushed hazard persists.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:       if (hazard && !bus.flush_i)   state_q <= INTERLOCK;
        INTERLOCK: if (!hazard || bus.flush_i)   state_q <= RUN;
        default:                                 state_q <= RUN;
      endcase
    end
  end

  assign bus.interlock_o = (state_q == INTERLOCK);
  assign bus.ex_valid_o  = ex_q.vld;
  assign bus.ex_aluop_o  = ex_q.aluop;
  assign bus.ex_alusel_o = ex_q.alusel;
  assign bus.ex_reg1_o   = ex_q.reg1;
  assign bus.ex_reg2_o   = ex_q.reg2;
  assign bus.ex_wd_o     = ex_q.wd;
  assign bus.ex_wreg_o   = ex_q.wreg;
  assign bus.stall_cnt_o = cnt_q;
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised successor to the combinational decode operand path: resolves source operands (immediate, regfile, N-way forwarding), detects load-use hazards and issues a stall request.
- Registers the decoded instruction into the ID/EX boundary, with hold, flush and bubble insertion.
- Sits between instruction decode and the execute stage.
- Keeps a saturating interlock-cycle counter for performance monitoring.

Parameters:
DW, 32, data/operand width
AW, 5, register address width
NUM_FWD, 2, number of forwarding sources; index 0 is youngest and has highest priority
OPW, 8, aluop width
SELW, 3, alusel width
CNTW, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
id_valid_i  in  1  decoded instruction present in ID
id_aluop_i  in  OPW  operation subtype
id_alusel_i  in  SELW  operation type
id_wd_i  in  AW  destination register
id_wreg_i  in  1  destination write enable
id_imm_i  in  DW  immediate, already extended by decoder
id_rd1_i / id_rd2_i  in  1  source 1/2 read enable
id_ra1_i / id_ra2_i  in  AW  source 1/2 address
rf_data1_i / rf_data2_i  in  DW  regfile read data
fwd_wreg_i  in  NUM_FWD  per-source write enable
fwd_wd_i  in  NUM_FWD*AW  per-source destination, source i at [i*AW +: AW]
fwd_wdata_i  in  NUM_FWD*DW  per-source result
fwd_load_i  in  NUM_FWD  per-source flag: result not yet available (load in flight)
ex_ready_i  in  1  execute stage can accept
flush_i  in  1  squash ID and ID/EX contents
clr_cnt_i  in  1  clear stall counter
stall_req_o  out  1  hold fetch/decode this cycle
interlock_o  out  1  FSM in INTERLOCK
ex_valid_o  out  1  registered: instruction valid in EX
ex_aluop_o  out  OPW  registered
ex_alusel_o  out  SELW  registered
ex_reg1_o / ex_reg2_o  out  DW  registered operands
ex_wd_o  out  AW  registered
ex_wreg_o  out  1  registered
stall_cnt_o  out  CNTW  interlock cycle count

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0, asynchronous): all registered outputs 0; FSM in RUN; stall_cnt_o=0.
- Operand select, combinational, per source k in {1,2}, in priority order:
  - rdk=0: immediate.
  - rak=0: zero. Register 0 never forwards and never hazards.
  - Otherwise scan i=0..NUM_FWD-1 and take the first i with fwd_wreg[i]=1 and fwd_wd[i]=rak.
    - fwd_load[i]=1: hazard_k=1, operand don't-care.
    - fwd_load[i]=0: operand = fwd_wdata[i].
  - No match: rf_datak_i.
- hazard = id_valid_i & (hazard_1 | hazard_2).
- stall_req_o = !flush_i & id_valid_i & (hazard | !ex_ready_i). Combinational; upstream holds ID inputs while it is high.
- ID/EX register update, 1-cycle latency, evaluated in this order:
  - flush_i=1: bubble, regardless of ex_ready_i.
  - else ex_ready_i=0: hold all outputs.
  - else id_valid_i=1 and hazard=0: load id_* fields and resolved operands; ex_valid_o=1.
  - else: bubble.
- Bubble: ex_valid_o=0, ex_wreg_o=0, aluop/alusel/wd/operands = 0.
- FSM states: RUN, INTERLOCK.
  - RUN -> INTERLOCK: hazard=1 and flush_i=0.
  - INTERLOCK -> RUN: hazard=0 or flush_i=1.
  - interlock_o = (state==INTERLOCK).
- stall_cnt_o:
  - clr_cnt_i has priority: counter becomes 0 next cycle.
  - Otherwise +1 each cycle with hazard=1 and flush_i=0.
  - Saturates at all-ones and does not wrap.
- Hazard and !ex_ready_i together: hold wins, no bubble is inserted, and the counter still increments.
- Reset mid-interlock: immediate return to reset state; the pending instruction is lost. Upstream is also reset.

Test Plan:
- Forward priority, NUM_FWD=2: ra1=3, fwd0=(wreg1, wd3, 0x11), fwd1=(wreg1, wd3, 0x22), rf=0x33, rd1=1 -> ex_reg1_o=0x11 next cycle, ex_valid_o=1.
- Zero register and immediate: ra1=0 with fwd0 targeting 0 (data 0xFF); rd2=0, imm=0x1234 -> ex_reg1_o=0, ex_reg2_o=0x1234.
- Load-use interlock: fwd0 wd=5 with load=1 for 2 cycles, ra2=5 -> stall_req_o=1 for 2 cycles, 2 bubbles issued, interlock_o=1, stall_cnt_o=2. On load=0, data 0xAB -> ex_reg2_o=0xAB, ex_valid_o=1.
- Backpressure: ex_ready_i=0 for 3 cycles with a valid instruction -> outputs held unchanged, stall_req_o=1, counter unchanged.
- Flush during interlock: hazard active and flush_i=1 -> stall_req_o=0, next cycle ex_valid_o=0 and FSM in RUN.
- Saturation and clear, CNTW=4: 20 hazard cycles -> stall_cnt_o=15. Assert clr_cnt_i -> 0 the next cycle. Async rst=0 mid-sequence -> all outputs 0 immediately.
